tinyalu_arbiter: RTL and testbench
==================================

Name: tinyalu_arbiter

Overview:
- Sequences and shares one tinyalu instance among NUM_REQ requesters, using round-robin arbitration.
- Accepts one command per grant and drives the ALU's start/op/A/B interface.
- Holds start until the ALU signals done, then returns the 16-bit result, tagged with the requester index, on a single response channel with ready/valid handshake.
- Sits between the testbench/host command sources and tinyalu.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT_CYCLES, 15, max cycles start may be held without done (used only with the optional feature)

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester command valid
- req_ready  output  NUM_REQ  one-hot grant/accept, combinational in IDLE
- req_a  input  8*NUM_REQ  operand A, requester i at bits [8i+7:8i]
- req_b  input  8*NUM_REQ  operand B, same packing
- req_op  input  3*NUM_REQ  opcode, requester i at bits [3i+2:3i]
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response accepted
- rsp_id  output  $clog2(NUM_REQ)  index of the requester owning the response
- rsp_result  output  16  ALU result
- rsp_err  output  1  response produced by timeout abort
- alu_start  output  1  to tinyalu start
- alu_op  output  3  to tinyalu op
- alu_a  output  8  to tinyalu A
- alu_b  output  8  to tinyalu B
- alu_done  input  1  from tinyalu done
- alu_result  input  16  from tinyalu result
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, active-high):
  - state=IDLE; rr pointer = NUM_REQ-1, so requester 0 has first priority.
  - All outputs 0: req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, alu_start, alu_op, alu_a, alu_b, busy.
- States: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is set, grant the first set bit searching from rr+1 upward with wrap.
  - req_ready[g]=1 in that same cycle (combinational from state and req_valid).
  - Capture op/a/b/id into registers; rr<=g.
  - If captured op==3'b000: result=0, rsp_err=0, go to RESP. The ALU is not started because it never raises done for op 000.
  - Otherwise go to EXEC.
  - No req_valid: stay in IDLE; req_ready=0.
- EXEC:
  - alu_start=1; alu_op/a/b driven from the captured registers, constant for the whole state.
  - When alu_done==1 is sampled: capture alu_result into rsp_result, drop alu_start, go to RESP.
  - alu_done is ignored in every other state.
- RESP:
  - rsp_valid=1, with rsp_id/rsp_result/rsp_err held stable until rsp_valid&&rsp_ready.
  - On accept: rsp_valid<=0, go to IDLE.
  - alu_start is 0 throughout RESP and IDLE. This guarantees at least 2 cycles of start low between ALU operations, so the ALU done pipeline has drained before the next start.
- Latency, request accept (cycle 0) to rsp_valid, with rsp_ready tied high:
  - add/and/xor (op 001-011): done seen in cycle 2, rsp_valid in cycle 3.
  - mult (op[2]=1): done seen in cycle 5, rsp_valid in cycle 6.
  - op 000: rsp_valid in cycle 1.
- Width: alu_result is passed through unmodified; no truncation or extension.
- Fairness:
  - One command per grant.
  - A requester that keeps req_valid high is next served only after every other valid requester has been served once.
- req_valid deasserted by a requester while another requester is being served has no effect.
- Reset asserted mid-EXEC: start drops immediately (async); the in-flight command is discarded with no response.

Optional Feature:
- Macro: TINYALU_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to EXEC and increments each EXEC cycle.
  - If it reaches TIMEOUT_CYCLES without alu_done, alu_start<=0, rsp_result<=16'hDEAD, rsp_err<=1, go to RESP.
  - alu_done sampled in the same cycle the count is reached wins: normal response, rsp_err=0.
- Undefined:
  - No counter; EXEC waits indefinitely.
  - rsp_err is tied to 0.

Test Plan:
- Requester 1 only, op=001, A=8'hF0, B=8'h20, rsp_ready=1 -> rsp_valid in cycle 3 after accept; rsp_id=1; rsp_result=16'h0110; rsp_err=0.
- Requester 0, op=100, A=8'hFF, B=8'hFF -> alu_start high for exactly 5 cycles; rsp_result=16'hFE01 in cycle 6.
- All 4 requesters valid continuously, ops 010 with differing operands -> grant order 0,1,2,3,0; each rsp_id matches its AND result; alu_start low for at least 2 cycles between ops.
- Requester 2, op=000 -> no alu_start pulse; rsp_valid in cycle 1; rsp_result=0; rsp_id=2.
- rsp_ready held low for 10 cycles during an xor response -> rsp_valid, rsp_id, rsp_result stable; req_ready all 0; next grant only after the accept.
- Reset pulsed during mult EXEC -> all outputs 0 asynchronously; no response. With TINYALU_ARB_TIMEOUT_EN and alu_done forced 0: rsp_result=16'hDEAD, rsp_err=1 after 15 EXEC cycles.

Source files
------------

// File: rtl/tinyalu_arbiter.sv
// tinyalu_arbiter: round-robin sharing of one tinyalu among NUM_REQ requesters.
// One command is accepted per grant. The captured command is held on the ALU
// interface until done, and the result is returned on a ready/valid response
// channel tagged with the requester index.
// Optional build macro TINYALU_ARB_TIMEOUT_EN: aborts an EXEC that lasts
// TIMEOUT_CYCLES cycles without done, and answers with 16'hDEAD and rsp_err=1.
module tinyalu_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [8*NUM_REQ-1:0]       req_a,
   input  logic [8*NUM_REQ-1:0]       req_b,
   input  logic [3*NUM_REQ-1:0]       req_op,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0] rsp_id,
   output logic [15:0]                rsp_result,
   output logic                       rsp_err,
   output logic                       alu_start,
   output logic [2:0]                 alu_op,
   output logic [7:0]                 alu_a,
   output logic [7:0]                 alu_b,
   input  logic                       alu_done,
   input  logic [15:0]                alu_result,
   output logic                       busy
);

   localparam int unsigned IdW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e           state_q, state_d;
   logic [IdW-1:0]   rr_q, rr_d;
   logic [IdW-1:0]   id_q, id_d;
   logic [2:0]       op_q, op_d;
   logic [7:0]       a_q, a_d;
   logic [7:0]       b_q, b_d;
   logic [15:0]      result_q, result_d;

   logic             grant_found;
   logic [IdW-1:0]   grant_idx;
   logic [IdW-1:0]   cidx;
   int unsigned      cand;
   logic [2:0]       sel_op;
   logic [7:0]       sel_a;
   logic [7:0]       sel_b;

`ifdef TINYALU_ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             err_q, err_d;
`endif

   // Round-robin search starting just above the last grant, plus operand mux.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      cidx        = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand = (32'(rr_q) + i) % NUM_REQ;
         cidx = cand[IdW-1:0];
         if (!grant_found && req_valid[cidx]) begin
            grant_found = 1'b1;
            grant_idx   = cidx;
         end
      end
      sel_op    = '0;
      sel_a     = '0;
      sel_b     = '0;
      req_ready = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (grant_idx == IdW'(j)) begin
            sel_op = req_op[3*j +: 3];
            sel_a  = req_a[8*j +: 8];
            sel_b  = req_b[8*j +: 8];
            // Grant is only visible while idle; other states never accept.
            req_ready[j] = (state_q == StIdle) && grant_found;
         end
      end
   end

   // Next-state logic: capture on grant, wait for done, hold response until accepted.
   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      id_d     = id_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
`ifdef TINYALU_ARB_TIMEOUT_EN
      cnt_d    = cnt_q;
      err_d    = err_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (grant_found) begin
               rr_d = grant_idx;
               id_d = grant_idx;
               op_d = sel_op;
               a_d  = sel_a;
               b_d  = sel_b;
`ifdef TINYALU_ARB_TIMEOUT_EN
               cnt_d = '0;
               err_d = 1'b0;
`endif
               // tinyalu never raises done for a no-op, so answer it directly.
               if (sel_op == 3'b000) begin
                  result_d = '0;
                  state_d  = StResp;
               end else begin
                  state_d  = StExec;
               end
            end
         end
         StExec: begin
            if (alu_done) begin
               result_d = alu_result;
               state_d  = StResp;
`ifdef TINYALU_ARB_TIMEOUT_EN
            end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
               result_d = 16'hDEAD;
               err_d    = 1'b1;
               state_d  = StResp;
            end else begin
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         StResp: begin
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and capture registers; reset gives requester 0 first priority.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         rr_q     <= IdW'(NUM_REQ - 1);
         id_q     <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
`ifdef TINYALU_ARB_TIMEOUT_EN
         cnt_q    <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         id_q     <= id_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
`ifdef TINYALU_ARB_TIMEOUT_EN
         cnt_q    <= cnt_d;
         err_q    <= err_d;
`endif
      end
   end

   assign alu_start  = (state_q == StExec);
   assign alu_op     = op_q;
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign rsp_valid  = (state_q == StResp);
   assign rsp_id     = id_q;
   assign rsp_result = result_q;
   assign busy       = (state_q != StIdle);
`ifdef TINYALU_ARB_TIMEOUT_EN
   assign rsp_err    = err_q;
`else
   assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Directed bench for tinyalu_arbiter with a behavioural tinyalu model
// (single-cycle ops: done one cycle after start; mult: done four cycles after start).
module tb_tinyalu_arbiter;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [N-1:0]  req_valid = '0;
   logic [N-1:0]  req_ready;
   logic [8*N-1:0] req_a = '0;
   logic [8*N-1:0] req_b = '0;
   logic [3*N-1:0] req_op = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [1:0]    rsp_id;
   logic [15:0]   rsp_result;
   logic          rsp_err;
   logic          alu_start;
   logic [2:0]    alu_op;
   logic [7:0]    alu_a;
   logic [7:0]    alu_b;
   logic          alu_done;
   logic [15:0]   alu_result;
   logic          busy;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   tinyalu_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(15)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_err    (rsp_err),
      .alu_start  (alu_start),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_done   (alu_done),
      .alu_result (alu_result),
      .busy       (busy)
   );

   // tinyalu model
   logic [4:0] alu_cnt;
   logic       done_kill = 1'b0;

   always_ff @(posedge clk) begin
      if (!alu_start) alu_cnt <= '0;
      else            alu_cnt <= alu_cnt + 5'd1;
   end

   always_comb begin
      alu_done   = alu_start && !done_kill && (alu_cnt == (alu_op[2] ? 5'd4 : 5'd1));
      alu_result = '0;
      if (alu_done) begin
         case (alu_op)
            3'b001:  alu_result = {8'h00, alu_a} + {8'h00, alu_b};
            3'b010:  alu_result = {8'h00, alu_a & alu_b};
            3'b011:  alu_result = {8'h00, alu_a ^ alu_b};
            default: alu_result = 16'({8'h00, alu_a} * {8'h00, alu_b});
         endcase
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      req_valid = '0;
      rsp_ready = 1'b1;
      reset     = 1'b1;
      tick;
      tick;
      reset     = 1'b0;
      #1;
   endtask

   task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b);
      req_op[3*i +: 3] = op;
      req_a[8*i +: 8]  = a;
      req_b[8*i +: 8]  = b;
      req_valid[i]     = 1'b1;
   endtask

   task automatic test_reset;
      do_reset;
      total++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready got %b want 0000", req_ready); else passed++;
      total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else passed++;
      total++; if ({rsp_id, rsp_result, rsp_err} !== 19'h0) $display("FAIL reset_rsp_fields got %h/%h/%b want 0", rsp_id, rsp_result, rsp_err); else passed++;
      total++; if ({alu_start, alu_op, alu_a, alu_b} !== 20'h0) $display("FAIL reset_alu_if got %b/%h/%h/%h want 0", alu_start, alu_op, alu_a, alu_b); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
   endtask

   task automatic test_single_add;
      int rc;
      logic [1:0] id;
      logic [15:0] res;
      logic err;
      rc = -1; id = '0; res = '0; err = 1'b1;
      do_reset;
      set_req(1, 3'b001, 8'hF0, 8'h20);
      #1;
      total++; if (req_ready !== 4'b0010) $display("FAIL add_grant got %b want 0010", req_ready); else passed++;
      tick;
      req_valid = '0;
      total++; if ({alu_start, alu_op, alu_a, alu_b} !== {1'b1, 3'b001, 8'hF0, 8'h20}) $display("FAIL add_alu_drive got %b/%h/%h/%h want 1/1/f0/20", alu_start, alu_op, alu_a, alu_b); else passed++;
      for (int k = 1; k <= 10; k++) begin
         if (rsp_valid && rc < 0) begin
            rc = k; id = rsp_id; res = rsp_result; err = rsp_err;
         end
         tick;
      end
      total++; if (rc !== 3) $display("FAIL add_latency got %0d want 3", rc); else passed++;
      total++; if (id !== 2'd1) $display("FAIL add_rsp_id got %0d want 1", id); else passed++;
      total++; if (res !== 16'h0110) $display("FAIL add_result got %h want 0110", res); else passed++;
      total++; if (err !== 1'b0) $display("FAIL add_err got %b want 0", err); else passed++;
   endtask

   task automatic test_mult;
      int rc, starts;
      logic [15:0] res;
      rc = -1; starts = 0; res = '0;
      do_reset;
      set_req(0, 3'b100, 8'hFF, 8'hFF);
      #1;
      tick;
      req_valid = '0;
      for (int k = 1; k <= 12; k++) begin
         if (alu_start) starts++;
         if (rsp_valid && rc < 0) begin
            rc = k; res = rsp_result;
         end
         tick;
      end
      total++; if (starts !== 5) $display("FAIL mult_start_cycles got %0d want 5", starts); else passed++;
      total++; if (rc !== 6) $display("FAIL mult_latency got %0d want 6", rc); else passed++;
      total++; if (res !== 16'hFE01) $display("FAIL mult_result got %h want fe01", res); else passed++;
   endtask

   task automatic test_fairness;
      logic [7:0] av [4];
      logic [7:0] bv [4];
      int order [5];
      int n, low_run, min_low;
      logic prev_start, seen_op;
      av = '{8'h0F, 8'hAA, 8'hF0, 8'h81};
      bv = '{8'hFF, 8'hF0, 8'h3C, 8'hC3};
      order = '{0, 1, 2, 3, 0};
      n = 0; low_run = 0; min_low = 99; prev_start = 1'b0; seen_op = 1'b0;
      do_reset;
      for (int i = 0; i < N; i++) set_req(i, 3'b010, av[i], bv[i]);
      #1;
      for (int k = 0; k < 60 && n < 5; k++) begin
         if (alu_start) begin
            if (!prev_start && seen_op && low_run < min_low) min_low = low_run;
            seen_op = 1'b1;
            low_run = 0;
         end else begin
            low_run++;
         end
         prev_start = alu_start;
         if (rsp_valid) begin
            total++; if (rsp_id !== 2'(order[n])) $display("FAIL rr_order_%0d got %0d want %0d", n, rsp_id, order[n]); else passed++;
            total++; if (rsp_result !== {8'h00, av[order[n]] & bv[order[n]]}) $display("FAIL rr_result_%0d got %h want %h", n, rsp_result, {8'h00, av[order[n]] & bv[order[n]]}); else passed++;
            n++;
            if (n == 5) req_valid = '0;
         end
         tick;
      end
      total++; if (n !== 5) $display("FAIL rr_rsp_count got %0d want 5", n); else passed++;
      total++; if (!(min_low >= 2 && min_low < 99)) $display("FAIL rr_start_gap got %0d want >=2", min_low); else passed++;
   endtask

   // Runs straight after the fairness test so rsp_result holds a non-zero value.
   task automatic test_op_zero;
      set_req(2, 3'b000, 8'h12, 8'h34);
      #1;
      total++; if (req_ready !== 4'b0100) $display("FAIL nop_grant got %b want 0100", req_ready); else passed++;
      tick;
      req_valid = '0;
      total++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 2'd2, 16'h0000}) $display("FAIL nop_rsp got %b/%0d/%h want 1/2/0000", rsp_valid, rsp_id, rsp_result); else passed++;
      total++; if (alu_start !== 1'b0) $display("FAIL nop_no_start got %b want 0", alu_start); else passed++;
      tick;
      total++; if ({rsp_valid, busy, alu_start} !== 3'b000) $display("FAIL nop_idle got %b want 000", {rsp_valid, busy, alu_start}); else passed++;
   endtask

   task automatic test_back_to_back;
      int k, rc;
      logic [1:0] id;
      logic [15:0] res;
      rc = -1; id = '0; res = '0;
      do_reset;
      rsp_ready = 1'b0;
      set_req(0, 3'b011, 8'h5A, 8'h0F);
      set_req(1, 3'b001, 8'h01, 8'h02);
      #1;
      tick;
      req_valid[0] = 1'b0;
      k = 0;
      while (!rsp_valid && k < 10) begin
         tick;
         k++;
      end
      total++; if (rsp_valid !== 1'b1) $display("FAIL bp_rsp_arrives got %b want 1", rsp_valid); else passed++;
      for (int c = 0; c < 10; c++) begin
         total++; if ({rsp_valid, rsp_id, rsp_result, req_ready, alu_start} !== {1'b1, 2'd0, 16'h0055, 4'b0000, 1'b0}) $display("FAIL bp_hold_%0d got %b/%0d/%h/%b/%b want 1/0/0055/0000/0", c, rsp_valid, rsp_id, rsp_result, req_ready, alu_start); else passed++;
         tick;
      end
      rsp_ready = 1'b1;
      tick;
      total++; if (req_ready !== 4'b0010) $display("FAIL bp_next_grant got %b want 0010", req_ready); else passed++;
      tick;
      req_valid = '0;
      for (int c = 0; c < 10; c++) begin
         if (rsp_valid && rc < 0) begin
            rc = c; id = rsp_id; res = rsp_result;
         end
         tick;
      end
      total++; if ({id, res} !== {2'd1, 16'h0003}) $display("FAIL bp_second_rsp got %0d/%h want 1/0003", id, res); else passed++;
   endtask

   // Runs without a prior reset so the captured registers are non-zero beforehand.
   task automatic test_reset_mid_exec;
      int seen;
      seen = 0;
      set_req(0, 3'b100, 8'hFF, 8'hFF);
      #1;
      tick;
      req_valid = '0;
      tick;
      total++; if (alu_start !== 1'b1) $display("FAIL rst_exec_start got %b want 1", alu_start); else passed++;
      reset = 1'b1;
      #1;
      total++; if ({alu_start, busy, rsp_valid, alu_op, alu_a} !== 14'h0) $display("FAIL rst_async_alu got %b/%b/%b/%h/%h want 0", alu_start, busy, rsp_valid, alu_op, alu_a); else passed++;
      total++; if (rsp_result !== 16'h0000) $display("FAIL rst_async_result got %h want 0000", rsp_result); else passed++;
      tick;
      reset = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (rsp_valid || alu_start) seen++;
         tick;
      end
      total++; if (seen !== 0) $display("FAIL rst_no_response got %0d want 0", seen); else passed++;
   endtask

`ifdef TINYALU_ARB_TIMEOUT_EN
   task automatic test_timeout;
      int rc, starts;
      logic [15:0] res;
      logic err;
      rc = -1; starts = 0; res = '0; err = 1'b0;
      do_reset;
      done_kill = 1'b1;
      set_req(0, 3'b001, 8'h11, 8'h22);
      #1;
      tick;
      req_valid = '0;
      for (int k = 1; k <= 30; k++) begin
         if (alu_start) starts++;
         if (rsp_valid && rc < 0) begin
            rc = k; res = rsp_result; err = rsp_err;
         end
         tick;
      end
      done_kill = 1'b0;
      total++; if (starts !== 15) $display("FAIL to_start_cycles got %0d want 15", starts); else passed++;
      total++; if (rc !== 16) $display("FAIL to_latency got %0d want 16", rc); else passed++;
      total++; if ({res, err} !== {16'hDEAD, 1'b1}) $display("FAIL to_rsp got %h/%b want dead/1", res, err); else passed++;
   endtask
`endif

   initial begin
      test_reset;
      test_single_add;
      test_mult;
      test_fairness;
      test_op_zero;
      test_back_to_back;
      test_reset_mid_exec;
`ifdef TINYALU_ARB_TIMEOUT_EN
      test_timeout;
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
